// File: rtl/photo_reader_ctl_if.sv
// Tape-source and computer-input handshake bundle for the phototape reader controller.
// master is the controller side, slave is the tape source / computer input side.
interface photo_reader_ctl_if;
  logic       tape_valid;
  logic [4:0] tape_data;
  logic       tape_end;
  logic       tape_ready;
  logic       rd_valid;
  logic [4:0] rd_data;
  logic       rd_ready;

  modport master (
    input  tape_valid, tape_data, tape_end, rd_ready,
    output tape_ready, rd_valid, rd_data
  );

  modport slave (
    output tape_valid, tape_data, tape_end, rd_ready,
    input  tape_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/photo_reader_ctl.sv
// Phototape reader sequencer: motor spin-up, frame fetch, paced delivery, stop on stop code.
//   state     | meaning
//   S_IDLE    | reader stopped, waiting for start
//   S_SPINUP  | motor spinning up, counting SPINUP_MS ticks
//   S_FETCH   | asking tape source for the next frame
//   S_DELIVER | frame presented to computer input
//   S_PACE    | holding off FRAME_MS ticks before next fetch
module photo_reader_ctl #(
  parameter int         SPINUP_MS = 20,
  parameter int         FRAME_MS  = 4,
  parameter logic [4:0] STOP_CODE = 5'b10000
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              tick_ms,
  input  logic              start,
  input  logic              abort,
  photo_reader_ctl_if.master bus,
  output logic              WAIT_FOR_TAPE,
  output logic              stop_seen,
  output logic              tape_err
);

  localparam int MAX_MS = (SPINUP_MS > FRAME_MS) ? SPINUP_MS : FRAME_MS;
  localparam int CW     = $clog2(MAX_MS + 1);
  localparam logic [CW-1:0] SPINUP_N = CW'(SPINUP_MS);
  localparam logic [CW-1:0] FRAME_N  = CW'(FRAME_MS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPINUP  = 3'd1,
    S_FETCH   = 3'd2,
    S_DELIVER = 3'd3,
    S_PACE    = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ms_cnt;
  logic [4:0]    rd_data_q;
  logic          stop_nxt;
  logic          err_set;
  logic          err_clr;
  logic          latch_en;
  logic          cnt_clr;
  logic          cnt_run;

  always_comb begin
    state_nxt = state;
    stop_nxt  = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    latch_en  = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_SPINUP;
            err_clr   = 1'b1;
          end
        end
        S_SPINUP: begin
          if (ms_cnt == SPINUP_N) state_nxt = S_FETCH;
        end
        S_FETCH: begin
          // a frame arriving alongside tape_end still gets handled as a frame
          if (bus.tape_valid) begin
            latch_en = 1'b1;
            if (bus.tape_data == STOP_CODE) begin
              stop_nxt  = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_DELIVER;
            end
          end else if (bus.tape_end) begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_DELIVER: begin
          if (bus.rd_ready) state_nxt = S_PACE;
        end
        S_PACE: begin
          if (ms_cnt == FRAME_N) state_nxt = S_FETCH;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Clearing on the transition edge means a tick in the entry cycle is never counted.
  assign cnt_clr = (state_nxt != state) &&
                   ((state_nxt == S_SPINUP) || (state_nxt == S_PACE));
  assign cnt_run = tick_ms && ((state == S_SPINUP) || (state == S_PACE)) &&
                   (ms_cnt != {CW{1'b1}});

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ms_cnt    <= '0;
      rd_data_q <= '0;
      stop_seen <= 1'b0;
      tape_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      stop_seen <= stop_nxt;
      if (latch_en) rd_data_q <= bus.tape_data;
      if (err_set)      tape_err <= 1'b1;
      else if (err_clr) tape_err <= 1'b0;
      if (cnt_clr)      ms_cnt <= '0;
      else if (cnt_run) ms_cnt <= ms_cnt + 1'b1;
    end
  end

  assign bus.tape_ready = (state == S_FETCH);
  assign bus.rd_valid   = (state == S_DELIVER);
  assign bus.rd_data    = rd_data_q;
  assign WAIT_FOR_TAPE  = (state != S_IDLE);

endmodule

// File: tb/tb_photo_reader_ctl.sv
// Directed bench for photo_reader_ctl: tape source model feeds a queue-based scoreboard
// of frames expected at the computer input; timing checked in tick_ms units.
module tb_photo_reader_ctl;
  localparam int TICK_DIV = 5;
  localparam logic [4:0] STOP = 5'b10000;

  logic CLOCK = 1'b0;
  logic rst, tick_ms, start, abort;
  logic WAIT_FOR_TAPE, stop_seen, tape_err;

  photo_reader_ctl_if bus ();

  photo_reader_ctl #(.SPINUP_MS(20), .FRAME_MS(4), .STOP_CODE(STOP)) dut (
    .CLOCK         (CLOCK),
    .rst           (rst),
    .tick_ms       (tick_ms),
    .start         (start),
    .abort         (abort),
    .bus           (bus.master),
    .WAIT_FOR_TAPE (WAIT_FOR_TAPE),
    .stop_seen     (stop_seen),
    .tape_err      (tape_err)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;
  int tick_ph = 0;
  int ticks = 0;
  int hs_cnt = 0;
  int stop_cnt = 0;
  logic [4:0] tape_q[$];
  logic [4:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive tick/tape source, then account handshakes seen at the edge.
  task automatic step();
    logic hs, acc, sa;
    logic [4:0] seen_rd;
    logic [4:0] seen_tape;
    tick_ms = (tick_ph == TICK_DIV - 1);
    tick_ph = (tick_ph + 1) % TICK_DIV;
    bus.tape_valid = (tape_q.size() > 0);
    bus.tape_data  = bus.tape_valid ? tape_q[0] : 5'h00;
    hs  = bus.rd_valid && bus.rd_ready;
    acc = bus.tape_ready && bus.tape_valid;
    sa  = start && !abort && !WAIT_FOR_TAPE;
    seen_rd   = bus.rd_data;
    seen_tape = bus.tape_data;
    if (tick_ms) ticks++;
    if (hs || sa) ticks = 0;
    @(posedge CLOCK);
    #1;
    if (acc) begin
      void'(tape_q.pop_front());
      if (!abort && seen_tape != STOP) exp_q.push_back(seen_tape);
    end
    if (hs) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("sb_unexpected_frame", 32'(seen_rd), 32'hFFFF);
      else chk("sb_rd_data", 32'(seen_rd), 32'(exp_q.pop_front()));
    end
    if (stop_seen) stop_cnt++;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_ticks);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tape_ready && n < 1000);
    chk({tag, "_ready"}, 32'(bus.tape_ready), 1);
    chk({tag, "_ticks"}, ticks, exp_ticks);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (WAIT_FOR_TAPE && n < 1000);
    chk({tag, "_idle"}, 32'(WAIT_FOR_TAPE), 0);
  endtask

  initial begin
    int bad, hs0, st0;
    rst = 1'b1; tick_ms = 1'b0; start = 1'b0; abort = 1'b0;
    bus.tape_valid = 1'b0; bus.tape_data = 5'h00; bus.tape_end = 1'b0; bus.rd_ready = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1 rst = 1'b0;
    step();
    chk("rst_tape_ready", 32'(bus.tape_ready), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_wait", 32'(WAIT_FOR_TAPE), 0);
    chk("rst_stop_seen", 32'(stop_seen), 0);
    chk("rst_tape_err", 32'(tape_err), 0);

    // normal read: 03, 1F, stop
    tape_q = '{5'h03, 5'h1F, STOP};
    bus.rd_ready = 1'b1;
    kick();
    chk("norm_wait_rise", 32'(WAIT_FOR_TAPE), 1);
    wait_ready("norm_spinup", 20);
    wait_ready("norm_pace1", 4);
    wait_ready("norm_pace2", 4);
    wait_idle("norm_stop");
    repeat (10) step();
    chk("norm_stop_pulses", stop_cnt, 1);
    chk("norm_frames", hs_cnt, 2);
    chk("norm_sb_empty", exp_q.size(), 0);
    chk("norm_no_rd_valid", 32'(bus.rd_valid), 0);

    // backpressure: computer stalls 50 cycles
    tape_q = '{5'h0A, STOP};
    bus.rd_ready = 1'b0;
    kick();
    wait_ready("bp_spinup", 20);
    step();
    hs0 = hs_cnt;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!(bus.rd_valid === 1'b1 && bus.rd_data === 5'h0A)) bad++;
    end
    chk("bp_hold", bad, 0);
    bus.rd_ready = 1'b1;
    step();
    chk("bp_handshake", hs_cnt, hs0 + 1);
    chk("bp_rd_valid_drop", 32'(bus.rd_valid), 0);
    wait_idle("bp_stop");
    chk("bp_stop_pulses", stop_cnt, 2);

    // tape end with no frames, then restart clears tape_err
    bus.tape_end = 1'b1;
    kick();
    wait_idle("end_idle");
    chk("end_tape_err", 32'(tape_err), 1);
    kick();
    chk("end_err_cleared", 32'(tape_err), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    bus.tape_end = 1'b0;

    // abort during PACE
    tape_q = '{5'h05, 5'h06, STOP};
    st0 = stop_cnt;
    kick();
    wait_ready("abp_spinup", 20);
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abp_wait", 32'(WAIT_FOR_TAPE), 0);
    chk("abp_rd_valid", 32'(bus.rd_valid), 0);
    chk("abp_stop_seen", 32'(stop_seen), 0);
    tape_q.delete();

    // abort during DELIVER
    tape_q = '{5'h07, STOP};
    bus.rd_ready = 1'b0;
    kick();
    wait_ready("abd_spinup", 20);
    step();
    chk("abd_rd_valid_pre", 32'(bus.rd_valid), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abd_wait", 32'(WAIT_FOR_TAPE), 0);
    chk("abd_rd_valid", 32'(bus.rd_valid), 0);
    chk("abd_stop_seen", 32'(stop_seen), 0);
    tape_q.delete();
    exp_q.delete();
    bus.rd_ready = 1'b1;

    // abort coincident with stop-code fetch
    tape_q = '{STOP};
    kick();
    wait_ready("abs_spinup", 20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abs_stop_seen", 32'(stop_seen), 0);
    chk("abs_wait", 32'(WAIT_FOR_TAPE), 0);
    repeat (5) step();
    chk("abs_stop_count", stop_cnt, st0);

    // async reset mid-DELIVER, restart with start held
    tape_q = '{5'h09, STOP};
    bus.rd_ready = 1'b0;
    kick();
    wait_ready("rst_spinup_a", 20);
    step();
    chk("rst_in_deliver", 32'(bus.rd_valid), 1);
    #3 rst = 1'b1;
    #1;
    chk("arst_rd_valid", 32'(bus.rd_valid), 0);
    chk("arst_rd_data", 32'(bus.rd_data), 0);
    chk("arst_wait", 32'(WAIT_FOR_TAPE), 0);
    chk("arst_tape_ready", 32'(bus.tape_ready), 0);
    chk("arst_flags", 32'({stop_seen, tape_err}), 0);
    exp_q.delete();
    start = 1'b1;
    #2 rst = 1'b0;
    step();
    start = 1'b0;
    chk("arst_restart", 32'(WAIT_FOR_TAPE), 1);
    bus.rd_ready = 1'b1;
    wait_ready("arst_spinup", 20);
    wait_idle("arst_stop");
    chk("arst_stop_count", stop_cnt, st0 + 1);

    // tick in the same cycle as SPINUP entry is not counted
    tape_q = '{STOP};
    tick_ph = TICK_DIV - 1;
    kick();
    chk("tickb_entry_tick", 32'(tick_ms), 1);
    wait_ready("tickb_spinup", 20);
    wait_idle("tickb_stop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout observed=1 expected=0");
    $fatal(1, "watchdog");
  end
endmodule
